// File: rtl/riscv_mem_access_unit.sv
// riscv_mem_access_unit: load/store sequencer driving a valid/ready word memory port with lane alignment and load extension.
// Define MISALIGN_TRAP_EN to trap misaligned half/word accesses instead of issuing them.
module riscv_mem_access_unit #(
    parameter int unsigned RESP_TIMEOUT = 255,
    parameter int unsigned ADDR_WIDTH   = 32
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic                  in_memrw,
    input  logic [1:0]            in_load_sel,
    input  logic                  in_load_unsigned,
    input  logic [1:0]            in_store_sel,
    input  logic [3:0]            in_store_mask,
    input  logic [ADDR_WIDTH-1:0] in_addr,
    input  logic [31:0]           in_wdata,
    output logic                  mem_req_valid,
    input  logic                  mem_req_ready,
    output logic [ADDR_WIDTH-1:0] mem_req_addr,
    output logic [3:0]            mem_req_wen,
    output logic [31:0]           mem_req_wdata,
    input  logic                  mem_resp_valid,
    input  logic [31:0]           mem_resp_data,
    output logic                  busy,
    output logic                  done,
    output logic [31:0]           rdata,
    output logic                  err
);
    typedef enum logic [2:0] {IDLE, REQ, RESP, DONE, ERR} state_t;
    localparam logic [31:0] TIMEOUT = 32'(RESP_TIMEOUT);
`ifdef MISALIGN_TRAP_EN
    localparam bit TRAP_EN = 1'b1;
`else
    localparam bit TRAP_EN = 1'b0;
`endif
    state_t                state_q, state_d;
    logic                  memrw_q, uns_q;
    logic [1:0]            sel_q, off_q;
    logic [ADDR_WIDTH-1:0] addr_q;
    logic [3:0]            wen_q;
    logic [31:0]           wdata_q, rdata_q, cnt_q, shifted, load_d;
    logic [1:0]            size;
    logic                  misalign, timed_out;
    assign size      = in_memrw ? in_store_sel : in_load_sel;
    assign misalign  = TRAP_EN && (size[1] ? in_addr[1:0] != 2'b00 : size[0] & in_addr[0]);
    // A response in the limit cycle takes priority, so only a silent cycle can time out.
    assign timed_out = TIMEOUT != 32'd0 && cnt_q + 32'd1 == TIMEOUT;
    assign shifted   = mem_resp_data >> {off_q, 3'b000};
    assign load_d    = sel_q == 2'b00 ? {{24{shifted[7] & ~uns_q}}, shifted[7:0]} :
                       sel_q == 2'b01 ? {{16{shifted[15] & ~uns_q}}, shifted[15:0]} : shifted;
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (in_valid) state_d = misalign ? ERR : REQ;
            REQ:     if (mem_req_ready) state_d = memrw_q ? DONE : RESP;
            RESP:    state_d = mem_resp_valid ? DONE : timed_out ? ERR : RESP;
            default: state_d = IDLE;
        endcase
    end
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            memrw_q <= 1'b0;
            uns_q   <= 1'b0;
            sel_q   <= 2'b00;
            off_q   <= 2'b00;
            addr_q  <= '0;
            wen_q   <= 4'b0000;
            wdata_q <= '0;
            rdata_q <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            if (state_q == IDLE && in_valid) begin
                memrw_q <= in_memrw;
                uns_q   <= in_load_unsigned;
                sel_q   <= in_load_sel;
                off_q   <= in_addr[1:0];
                addr_q  <= {in_addr[ADDR_WIDTH-1:2], 2'b00};
                wen_q   <= in_memrw ? in_store_mask << in_addr[1:0] : 4'b0000;
                wdata_q <= in_memrw ? in_wdata << {in_addr[1:0], 3'b000} : '0;
            end
            cnt_q <= state_q == RESP ? cnt_q + 32'd1 : '0;
            if (state_q == RESP && mem_resp_valid) rdata_q <= load_d;
        end
    end
    assign in_ready      = state_q == IDLE;
    assign busy          = state_q != IDLE;
    assign mem_req_valid = state_q == REQ;
    assign done          = state_q == DONE;
    assign err           = state_q == ERR;
    assign mem_req_addr  = addr_q;
    assign mem_req_wen   = wen_q;
    assign mem_req_wdata = wdata_q;
    assign rdata         = rdata_q;
endmodule

// File: tb/tb_riscv_mem_access_unit.sv
// tb_riscv_mem_access_unit: directed and randomized load/store sequences against a byte-lane reference model.
module tb_riscv_mem_access_unit;
`ifdef MISALIGN_TRAP_EN
    localparam bit TRAP = 1'b1;
`else
    localparam bit TRAP = 1'b0;
`endif
    logic        clk = 1'b0, reset = 1'b1;
    logic        in_valid = 0, in_ready, in_memrw = 0, in_load_unsigned = 0;
    logic [1:0]  in_load_sel = 0, in_store_sel = 0;
    logic [3:0]  in_store_mask = 0, mem_req_wen;
    logic [31:0] in_addr = 0, in_wdata = 0, mem_req_addr, mem_req_wdata, mem_resp_data = 0, rdata;
    logic        mem_req_valid, mem_req_ready = 0, mem_resp_valid = 0, busy, done, err;
    logic [31:0] exp_rdata = 0;
    int          checks = 0, errors = 0;

    riscv_mem_access_unit #(.RESP_TIMEOUT(4), .ADDR_WIDTH(32)) dut (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready), .in_memrw(in_memrw),
        .in_load_sel(in_load_sel), .in_load_unsigned(in_load_unsigned), .in_store_sel(in_store_sel),
        .in_store_mask(in_store_mask), .in_addr(in_addr), .in_wdata(in_wdata),
        .mem_req_valid(mem_req_valid), .mem_req_ready(mem_req_ready), .mem_req_addr(mem_req_addr),
        .mem_req_wen(mem_req_wen), .mem_req_wdata(mem_req_wdata), .mem_resp_valid(mem_resp_valid),
        .mem_resp_data(mem_resp_data), .busy(busy), .done(done), .rdata(rdata), .err(err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic int nbytes(input logic [1:0] sel);
        return sel == 2'd0 ? 1 : sel == 2'd1 ? 2 : 4;
    endfunction

    function automatic bit is_mis(input logic [1:0] sel, input logic [1:0] o);
        int n = nbytes(sel);
        return TRAP && ((n == 2 && o[0]) || (n == 4 && o != 2'd0));
    endfunction

    function automatic logic [31:0] ld_model(input logic [31:0] w, input logic [1:0] o,
                                             input logic [1:0] sel, input logic uns);
        int     n  = nbytes(sel);
        int     oi = int'(o);
        longint v  = 0;
        for (int i = 0; i < n; i++)
            if (oi + i < 4) v += longint'(w[8*(oi+i) +: 8]) << (8 * i);
        if (n < 4 && !uns && v >= (longint'(1) << (8 * n - 1))) v -= longint'(1) << (8 * n);
        return v[31:0];
    endfunction

    function automatic void st_model(input logic [31:0] wd, input logic [1:0] o, input logic [1:0] sel,
                                     output logic [3:0] wen, output logic [31:0] wdo);
        int n = nbytes(sel);
        wen = 4'b0000;
        wdo = 32'd0;
        for (int i = 0; i < 4; i++) begin
            int j = i - int'(o);
            if (j >= 0) begin
                wdo[8*i +: 8] = wd[8*j +: 8];
                if (j < n) wen[i] = 1'b1;
            end
        end
    endfunction

    task automatic access(input logic st, input logic [31:0] addr, input logic [1:0] sel, input logic uns,
                          input logic [31:0] data, input int req_dly, input int resp_dly);
        logic [3:0]  ewen;
        logic [31:0] ewd;
        st_model(data, addr[1:0], sel, ewen, ewd);
        if (!st) begin
            ewen = 4'b0000;
            ewd  = 32'd0;
        end
        in_valid = 1; in_memrw = st; in_addr = addr; in_wdata = $urandom;
        in_load_sel = sel; in_store_sel = sel; in_load_unsigned = uns;
        in_store_mask = sel == 2'd0 ? 4'b0001 : sel == 2'd1 ? 4'b0011 : 4'b1111;
        if (st) in_wdata = data;
        chk("idle_ready", {31'd0, in_ready}, 32'd1);
        step();
        in_valid = 0;
        if (is_mis(sel, addr[1:0])) begin
            chk("mis_err", {31'd0, err}, 32'd1);
            chk("mis_noreq", {31'd0, mem_req_valid}, 32'd0);
            step();
            chk("mis_err_clear", {31'd0, err}, 32'd0);
            chk("mis_rdata", rdata, exp_rdata);
            return;
        end
        for (int c = 0; c <= req_dly; c++) begin
            chk("req_valid", {31'd0, mem_req_valid}, 32'd1);
            chk("req_addr", mem_req_addr, {addr[31:2], 2'b00});
            chk("req_wen", {28'd0, mem_req_wen}, {28'd0, ewen});
            chk("req_wdata", mem_req_wdata, ewd);
            chk("req_busy", {30'd0, busy, in_ready}, 32'd2);
            if (c == req_dly) mem_req_ready = 1;
            step();
        end
        mem_req_ready = 0;
        if (!st) begin
            for (int c = 0; c <= resp_dly; c++) begin
                chk("resp_wait", {29'd0, busy, done, mem_req_valid}, 32'd4);
                mem_resp_valid = c == resp_dly;
                mem_resp_data  = c == resp_dly ? data : $urandom;
                step();
            end
            mem_resp_valid = 0;
            exp_rdata = ld_model(data, addr[1:0], sel, uns);
        end
        chk("done_pulse", {29'd0, busy, done, err}, 32'd6);
        chk("done_rdata", rdata, exp_rdata);
        step();
        chk("after_done", {29'd0, busy, done, in_ready}, 32'd1);
        chk("rdata_hold", rdata, exp_rdata);
    endtask

    initial begin
        step();
        step();
        chk("rst_ctrl", {26'd0, mem_req_valid, busy, done, err, in_ready, 1'b0}, 32'd2);
        chk("rst_wen", {28'd0, mem_req_wen}, 32'd0);
        chk("rst_addr", mem_req_addr, 32'd0);
        chk("rst_wdata", mem_req_wdata, 32'd0);
        chk("rst_rdata", rdata, 32'd0);
        reset = 0;
        step();
        access(1, 32'h100, 2'd2, 0, 32'hDEADBEEF, 0, 0);
        access(1, 32'h103, 2'd0, 0, 32'h000000AB, 0, 0);
        access(1, 32'h102, 2'd1, 0, 32'h0000CAFE, 2, 0);
        access(0, 32'h101, 2'd0, 0, 32'h00008000, 0, 0);
        access(0, 32'h101, 2'd0, 1, 32'h00008000, 0, 0);
        access(0, 32'h102, 2'd1, 0, 32'h12345678, 5, 1);
        access(0, 32'h200, 2'd2, 0, 32'h89ABCDEF, 0, 3);
        access(0, 32'h102, 2'd2, 0, 32'hA1B2C3D4, 0, 0);
        // Timeout: no response for four RESP cycles, then a stale response
        in_valid = 1; in_memrw = 0; in_addr = 32'h104; in_load_sel = 2'd2; mem_req_ready = 1;
        step();
        in_valid = 0;
        step();
        mem_req_ready = 0;
        for (int c = 0; c < 4; c++) begin
            chk("tmo_wait", {30'd0, busy, err}, 32'd2);
            step();
        end
        chk("tmo_err", {29'd0, busy, err, done}, 32'd6);
        chk("tmo_rdata", rdata, exp_rdata);
        mem_resp_valid = 1; mem_resp_data = 32'h55555555;
        step();
        chk("late_resp", {29'd0, err, done, in_ready}, 32'd1);
        chk("late_rdata", rdata, exp_rdata);
        step();
        mem_resp_valid = 0;
        chk("late_idle", {30'd0, done, busy}, 32'd0);
        access(0, 32'h108, 2'd1, 1, 32'hFFFF8001, 1, 2);
        for (int k = 0; k < 40; k++)
            access(1'($urandom_range(1)), $urandom, 2'($urandom_range(2)), 1'($urandom_range(1)),
                   $urandom, $urandom_range(3), $urandom_range(3));
        // Reset in REQ abandons the access with no completion
        in_valid = 1; in_memrw = 0; in_addr = 32'h40; in_load_sel = 2'd2;
        step();
        in_valid = 0;
        chk("pre_rst_req", {31'd0, mem_req_valid}, 32'd1);
        #2 reset = 1;
        #1;
        chk("rst_async", {29'd0, mem_req_valid, busy, in_ready}, 32'd1);
        chk("rst_rdata_mid", rdata, 32'd0);
        exp_rdata = 0;
        mem_req_ready = 1;
        step();
        reset = 0;
        mem_req_ready = 0;
        for (int c = 0; c < 3; c++) begin
            chk("post_rst", {28'd0, mem_req_valid, busy, done, err}, 32'd0);
            step();
        end
        access(1, 32'h44, 2'd2, 0, 32'h0BADF00D, 0, 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
